mem_access_unit: RTL and testbench

//  Parametrised MEM-stage load/store unit; sits between EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with big-endian byte lanes, LL/SC and bus timeout.
// Optional MEM_ALIGN_EXC_EN: misaligned accesses trap instead of being force-aligned.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_signed_i,
    input  logic                  mem_ll_i,
    input  logic                  mem_sc_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  bus_err_o,
`ifdef MEM_ALIGN_EXC_EN
    output logic                  align_exc_o,
    output logic [ADDR_W-1:0]     bad_addr_o,
`endif
    output logic                  llbit_o
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]        in_size;
    logic [LB:0]       in_n;
    logic [LB-1:0]     in_mask;
    logic [LB-1:0]     in_off;
    logic [NB-1:0]     in_ones;
    logic [NB-1:0]     in_sel;
    logic [DATA_W-1:0] in_wdata;
    logic              in_exc;
    logic              sc_fail;
    logic              accept;
    logic              timeout;

    logic              we_r;
    logic              sgn_r;
    logic              ll_r;
    logic              sc_r;
    logic              kill_r;
    logic              err_r;
    logic              exc_r;
    logic              wreg_r;
    logic              llbit;
    logic [1:0]        size_r;
    logic [LB-1:0]     off_r;
    logic [NB-1:0]     sel_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic [ADDR_W-1:0] baddr_r;
    logic [4:0]        wd_r;
    logic [CW-1:0]     cnt;

    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_data;
    logic              ld_sign;
    int                ld_n;

    // LL/SC are always word accesses; dword collapses to word on a 32-bit bus
    always_comb begin
        in_size = mem_size_i;
        if (mem_ll_i || mem_sc_i || (DATA_W == 32 && mem_size_i == 2'd3))
            in_size = 2'd2;
    end

    assign in_n    = {{LB{1'b0}}, 1'b1} << in_size;
    assign in_mask = in_n[LB-1:0] - LB'(1);
    assign in_off  = addr_i[LB-1:0] & ~in_mask;

    always_comb begin
        in_ones = '0;
        for (int i = 0; i < NB; i++)
            in_ones[i] = (i < int'(in_n));
        in_sel = in_ones << (NB - int'(in_off) - int'(in_n));
    end

    always_comb begin
        unique case (in_size)
            2'd0:    in_wdata = {NB{wdata_i[7:0]}};
            2'd1:    in_wdata = {(NB/2){wdata_i[15:0]}};
            2'd2:    in_wdata = {(NB/4){wdata_i[31:0]}};
            default: in_wdata = wdata_i;
        endcase
    end

    // Offset 0 lives in the MSB lane, so shift the selected bytes down to bit 0
    always_comb begin
        ld_n     = 1 << size_r;
        ld_shift = bus_rdata_i >> ((NB - int'(off_r) - ld_n) * 8);
        unique case (size_r)
            2'd0:    ld_sign = ld_shift[7];
            2'd1:    ld_sign = ld_shift[15];
            2'd2:    ld_sign = ld_shift[31];
            default: ld_sign = ld_shift[DATA_W-1];
        endcase
        ld_sign = ld_sign & sgn_r;
        ld_data = '0;
        for (int i = 0; i < DATA_W; i++)
            ld_data[i] = (i < ld_n * 8) ? ld_shift[i] : ld_sign;
    end

    assign accept  = (state == IDLE) & mem_valid_i & ~flush_i;
    assign sc_fail = mem_sc_i & ~llbit;
    assign timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_MAX) && !bus_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nx = (in_exc || sc_fail) ? RESP : REQ;
            end
            REQ: begin
                if (bus_ack_i || timeout)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            sgn_r   <= 1'b0;
            ll_r    <= 1'b0;
            sc_r    <= 1'b0;
            kill_r  <= 1'b0;
            err_r   <= 1'b0;
            wreg_r  <= 1'b0;
            llbit   <= 1'b0;
            size_r  <= 2'd0;
            off_r   <= '0;
            sel_r   <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            baddr_r <= '0;
            wd_r    <= 5'd0;
            cnt     <= '0;
        end else begin
            if (flush_i)
                llbit <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_r    <= (mem_we_i & ~mem_ll_i) | mem_sc_i;
                        sgn_r   <= mem_signed_i;
                        ll_r    <= mem_ll_i & ~mem_sc_i;
                        sc_r    <= mem_sc_i;
                        size_r  <= in_size;
                        off_r   <= in_off;
                        sel_r   <= in_sel;
                        wdata_r <= in_wdata;
                        baddr_r <= {addr_i[ADDR_W-1:LB], {LB{1'b0}}};
                        wd_r    <= wd_i;
                        wreg_r  <= wreg_i;
                        cnt     <= '0;
                        kill_r  <= 1'b0;
                        err_r   <= 1'b0;
                        rdata_r <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (flush_i)
                        kill_r <= 1'b1;
                    if (bus_ack_i) begin
                        if (sc_r)
                            rdata_r <= DATA_W'(1);
                        else if (!we_r)
                            rdata_r <= ld_data;
                        // a flushed LL must not re-arm the link
                        if (ll_r && !flush_i && !kill_r)
                            llbit <= 1'b1;
                        if (sc_r)
                            llbit <= 1'b0;
                    end else if (timeout) begin
                        err_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    logic [ADDR_W-1:0] bad_addr_r;

    assign in_exc = |(addr_i[LB-1:0] & in_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_r      <= 1'b0;
            bad_addr_r <= '0;
        end else if (accept) begin
            exc_r      <= in_exc;
            bad_addr_r <= addr_i;
        end
    end

    assign align_exc_o = done_o & exc_r;
    assign bad_addr_o  = bad_addr_r;
`else
    assign in_exc = 1'b0;
    assign exc_r  = 1'b0;
`endif

    assign bus_req_o   = (state == REQ);
    assign bus_we_o    = bus_req_o & we_r;
    assign bus_addr_o  = bus_req_o ? baddr_r : '0;
    assign bus_sel_o   = bus_req_o ? sel_r : '0;
    assign bus_wdata_o = bus_req_o ? wdata_r : '0;
    assign stall_o     = ((state == IDLE) & mem_valid_i) | bus_req_o;
    assign done_o      = (state == RESP) & ~kill_r;
    assign wd_o        = wd_r;
    assign rdata_o     = rdata_r;
    assign wreg_o      = done_o & wreg_r & ~err_r & ~exc_r;
    assign bus_err_o   = done_o & err_r;
    assign llbit_o     = llbit;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses
// scored against a byte-offset reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_signed_i;
    logic        mem_ll_i;
    logic        mem_sc_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stall_o;
    logic        done_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] rdata_o;
    logic        bus_err_o;
`ifdef MEM_ALIGN_EXC_EN
    logic        align_exc_o;
    logic [31:0] bad_addr_o;
`endif
    logic        llbit_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_signed_i(mem_signed_i),
        .mem_ll_i(mem_ll_i), .mem_sc_i(mem_sc_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_o(stall_o), .done_o(done_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .rdata_o(rdata_o), .bus_err_o(bus_err_o),
`ifdef MEM_ALIGN_EXC_EN
        .align_exc_o(align_exc_o), .bad_addr_o(bad_addr_o),
`endif
        .llbit_o(llbit_o)
    );

    typedef struct {
        int          req_cycles;
        logic        stall_acc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        done;
        logic        done_after;
        logic [31:0] rdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        err;
        logic        stall_resp;
        logic        llbit;
        logic        exc;
        logic [31:0] bad;
    } obs_t;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte offset k of a word maps to bits [8*(3-k)+7 : 8*(3-k)]
    function automatic int m_bytes(logic [1:0] s);
        return (s == 2'd3) ? 4 : (1 << s);
    endfunction

    function automatic int m_off(logic [31:0] a, int n);
        int o;
        o = int'(a % 32'd4);
        return o - (o % n);
    endfunction

    function automatic logic [3:0] m_sel(int off, int n);
        logic [3:0] s;
        s = 4'b0000;
        for (int k = off; k < off + n; k++)
            s = s | (4'b1000 >> k);
        return s;
    endfunction

    function automatic logic [31:0] m_rep(logic [31:0] d, int n);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v = 64'd0;
        for (int j = 0; j < 4 / n; j++)
            v = v | (({32'd0, d} & mask) << (8 * n * j));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] rd, int off, int n, logic sgn);
        logic [63:0] v;
        v = 64'd0;
        for (int k = off; k < off + n; k++)
            v = (v << 8) | (({32'd0, rd} >> (8 * (3 - k))) & 64'hFF);
        if (sgn && ((v >> (8 * n - 1)) & 64'd1) != 64'd0)
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic run_access(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic        ll,
        input  logic        sc,
        input  logic [31:0] addr,
        input  logic [31:0] wdat,
        input  logic [4:0]  wd,
        input  logic        wreg,
        input  int          ack_at,
        input  logic [31:0] rd,
        output obs_t        o
    );
        o.req_cycles = 0;
        o.we = 1'b0;
        o.addr = 32'd0;
        o.sel = 4'd0;
        o.wdata = 32'd0;
        o.exc = 1'b0;
        o.bad = 32'd0;
        mem_valid_i = 1'b1;
        mem_we_i = we;
        mem_size_i = size;
        mem_signed_i = sgn;
        mem_ll_i = ll;
        mem_sc_i = sc;
        addr_i = addr;
        wdata_i = wdat;
        wd_i = wd;
        wreg_i = wreg;
        #1;
        o.stall_acc = stall_o;
        step;
        mem_valid_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus_req_o !== 1'b1)
                break;
            if (c == 1) begin
                o.we = bus_we_o;
                o.addr = bus_addr_o;
                o.sel = bus_sel_o;
                o.wdata = bus_wdata_o;
            end
            o.req_cycles++;
            if (c == ack_at) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = rd;
            end
            step;
            bus_ack_i = 1'b0;
            bus_rdata_i = 32'd0;
        end
        o.done = done_o;
        o.rdata = rdata_o;
        o.wd = wd_o;
        o.wreg = wreg_o;
        o.err = bus_err_o;
        o.stall_resp = stall_o;
        o.llbit = llbit_o;
`ifdef MEM_ALIGN_EXC_EN
        o.exc = align_exc_o;
        o.bad = bad_addr_o;
`endif
        step;
        o.done_after = done_o;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step;
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus_req_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall_o); end
        checks++; if (llbit_o !== 1'b0) begin errors++; $display("FAIL rst_llbit got %b want 0", llbit_o); end
        checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata_o); end
        checks++; if (wreg_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL rst_wreg_err got %b%b want 00", wreg_o, bus_err_o); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_load_ext;
        obs_t o;
        run_access(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h103, 32'd0, 5'd3, 1'b1, 2, 32'h000000F0, o);
        checks++; if (o.sel !== 4'b0001) begin errors++; $display("FAIL lb_sel got %b want 0001", o.sel); end
        checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h want 00000100", o.addr); end
        checks++; if (o.req_cycles != 2 || o.done !== 1'b1) begin errors++; $display("FAIL lb_latency got req=%0d done=%b want req=2 done=1", o.req_cycles, o.done); end
        checks++; if (o.rdata !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_rdata got %h want fffffff0", o.rdata); end
        checks++; if (o.wd !== 5'd3 || o.wreg !== 1'b1) begin errors++; $display("FAIL lb_wd got %0d/%b want 3/1", o.wd, o.wreg); end
        checks++; if (o.done_after !== 1'b0) begin errors++; $display("FAIL lb_done_pulse got %b want 0", o.done_after); end
        run_access(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h103, 32'd0, 5'd3, 1'b1, 2, 32'h000000F0, o);
        checks++; if (o.rdata !== 32'h000000F0) begin errors++; $display("FAIL lbu_rdata got %h want 000000f0", o.rdata); end
    endtask

    task automatic test_store;
        obs_t o;
        run_access(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1, 32'd0, o);
        checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", o.we); end
        checks++; if (o.sel !== 4'b0011) begin errors++; $display("FAIL sh_sel got %b want 0011", o.sel); end
        checks++; if (o.wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", o.wdata); end
        checks++; if (o.addr !== 32'h200) begin errors++; $display("FAIL sh_addr got %h want 00000200", o.addr); end
        checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL sh_done got %b want 1", o.done); end
    endtask

    task automatic test_llsc;
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h300, 32'd0, 5'd4, 1'b1, 1, 32'h11223344, o);
        checks++; if (o.llbit !== 1'b1) begin errors++; $display("FAIL ll_llbit got %b want 1", o.llbit); end
        checks++; if (o.rdata !== 32'h11223344 || o.we !== 1'b0) begin errors++; $display("FAIL ll_rdata got %h we=%b want 11223344 we=0", o.rdata, o.we); end
        run_access(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h300, 32'hCAFEBABE, 5'd5, 1'b1, 2, 32'd0, o);
        checks++; if (o.req_cycles != 2 || o.we !== 1'b1 || o.sel !== 4'hF) begin errors++; $display("FAIL sc_bus got req=%0d we=%b sel=%b want 2 1 1111", o.req_cycles, o.we, o.sel); end
        checks++; if (o.wdata !== 32'hCAFEBABE) begin errors++; $display("FAIL sc_wdata got %h want cafebabe", o.wdata); end
        checks++; if (o.rdata !== 32'd1 || o.done !== 1'b1) begin errors++; $display("FAIL sc_ok got %h done=%b want 1 done=1", o.rdata, o.done); end
        checks++; if (o.llbit !== 1'b0) begin errors++; $display("FAIL sc_llclr got %b want 0", o.llbit); end
        run_access(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h300, 32'h55555555, 5'd5, 1'b1, 1, 32'd0, o);
        checks++; if (o.req_cycles != 0) begin errors++; $display("FAIL sc2_nobus got %0d want 0", o.req_cycles); end
        checks++; if (o.rdata !== 32'd0 || o.done !== 1'b1) begin errors++; $display("FAIL sc2_fail got %h done=%b want 0 done=1", o.rdata, o.done); end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h400, 32'd0, 5'd7, 1'b1, 0, 32'd0, o);
        checks++; if (o.req_cycles != 16) begin errors++; $display("FAIL to_req_cycles got %0d want 16", o.req_cycles); end
        checks++; if (o.done !== 1'b1 || o.err !== 1'b1) begin errors++; $display("FAIL to_err got done=%b err=%b want 1 1", o.done, o.err); end
        checks++; if (o.wreg !== 1'b0 || o.rdata !== 32'd0) begin errors++; $display("FAIL to_wreg got %b %h want 0 0", o.wreg, o.rdata); end
        checks++; if (o.stall_resp !== 1'b0) begin errors++; $display("FAIL to_stall got %b want 0", o.stall_resp); end
    endtask

    task automatic test_align;
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h102, 32'd0, 5'd9, 1'b1, 1, 32'hA1B2C3D4, o);
`ifdef MEM_ALIGN_EXC_EN
        checks++; if (o.req_cycles != 0) begin errors++; $display("FAIL al_nobus got %0d want 0", o.req_cycles); end
        checks++; if (o.exc !== 1'b1 || o.bad !== 32'h102) begin errors++; $display("FAIL al_exc got %b %h want 1 00000102", o.exc, o.bad); end
        checks++; if (o.wreg !== 1'b0 || o.done !== 1'b1) begin errors++; $display("FAIL al_wreg got %b done=%b want 0 1", o.wreg, o.done); end
`else
        checks++; if (o.addr !== 32'h100 || o.sel !== 4'hF) begin errors++; $display("FAIL al_bus got %h %b want 00000100 1111", o.addr, o.sel); end
        checks++; if (o.rdata !== 32'hA1B2C3D4) begin errors++; $display("FAIL al_rdata got %h want a1b2c3d4", o.rdata); end
`endif
    endtask

    task automatic test_random;
        obs_t o;
        logic we, sgn, wreg;
        logic [1:0] size;
        logic [31:0] addr, wdat, rd, exp;
        logic [4:0] wd;
        int n, off, ack;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            wreg = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            wd = 5'($urandom_range(0, 31));
            addr = $urandom;
            wdat = $urandom;
            rd = $urandom;
            ack = $urandom_range(1, 4);
            n = m_bytes(size);
`ifdef MEM_ALIGN_EXC_EN
            addr = addr & ~32'(n - 1);
`endif
            off = m_off(addr, n);
            run_access(we, size, sgn, 1'b0, 1'b0, addr, wdat, wd, wreg, ack, rd, o);
            checks++; if (o.req_cycles != ack || o.stall_acc !== 1'b1) begin errors++; $display("FAIL rnd%0d_req got %0d stall=%b want %0d 1", i, o.req_cycles, o.stall_acc, ack); end
            checks++; if (o.sel !== m_sel(off, n)) begin errors++; $display("FAIL rnd%0d_sel got %b want %b", i, o.sel, m_sel(off, n)); end
            checks++; if (o.addr !== (addr & ~32'd3) || o.we !== we) begin errors++; $display("FAIL rnd%0d_addr got %h we=%b want %h we=%b", i, o.addr, o.we, addr & ~32'd3, we); end
            exp = we ? 32'd0 : m_load(rd, off, n, sgn);
            checks++; if (o.rdata !== exp) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, o.rdata, exp); end
            if (we) begin
                checks++; if (o.wdata !== m_rep(wdat, n)) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", i, o.wdata, m_rep(wdat, n)); end
            end
            checks++; if (o.done !== 1'b1 || o.done_after !== 1'b0 || o.wreg !== wreg || o.wd !== wd) begin errors++; $display("FAIL rnd%0d_done got %b%b wreg=%b wd=%0d want 10 %b %0d", i, o.done, o.done_after, o.wreg, o.wd, wreg, wd); end
        end
    endtask

    task automatic test_flush;
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h500, 32'd0, 5'd1, 1'b1, 1, 32'h0, o);
        mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2;
        mem_ll_i = 1'b0; mem_sc_i = 1'b0; addr_i = 32'h504;
        step;
        mem_valid_i = 1'b0;
        flush_i = 1'b1;
        step;
        flush_i = 1'b0;
        checks++; if (llbit_o !== 1'b0 || bus_req_o !== 1'b1) begin errors++; $display("FAIL fl_req got ll=%b req=%b want 0 1", llbit_o, bus_req_o); end
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h12345678;
        step;
        bus_ack_i = 1'b0;
        checks++; if (done_o !== 1'b0 || bus_req_o !== 1'b0) begin errors++; $display("FAIL fl_nodone got done=%b req=%b want 0 0", done_o, bus_req_o); end
        step;
        mem_valid_i = 1'b1;
        flush_i = 1'b1;
        step;
        mem_valid_i = 1'b0;
        flush_i = 1'b0;
        checks++; if (bus_req_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL fl_accept got req=%b done=%b want 0 0", bus_req_o, done_o); end
        step;
        checks++; if (done_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL fl_accept2 got done=%b stall=%b want 0 0", done_o, stall_o); end
    endtask

    task automatic test_rst_mid;
        obs_t o;
        run_access(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h600, 32'd0, 5'd2, 1'b1, 1, 32'h0, o);
        mem_valid_i = 1'b1; addr_i = 32'h604;
        step;
        mem_valid_i = 1'b0;
        checks++; if (bus_req_o !== 1'b1 || llbit_o !== 1'b1) begin errors++; $display("FAIL rm_pre got req=%b ll=%b want 1 1", bus_req_o, llbit_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus_req_o !== 1'b0 || llbit_o !== 1'b0) begin errors++; $display("FAIL rm_async got req=%b ll=%b want 0 0", bus_req_o, llbit_o); end
        #2 rst = 1'b0;
        step;
        checks++; if (bus_req_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rm_post got req=%b done=%b want 0 0", bus_req_o, done_o); end
    endtask

    initial begin
        rst = 1'b1;
        mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'd0;
        mem_signed_i = 1'b0; mem_ll_i = 1'b0; mem_sc_i = 1'b0;
        addr_i = 32'd0; wdata_i = 32'd0; wd_i = 5'd0; wreg_i = 1'b0;
        flush_i = 1'b0; bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
        test_reset;
        test_load_ext;
        test_store;
        test_llsc;
        test_timeout;
        test_align;
        test_random;
        test_flush;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
